// File: rtl/axi4_lite_mst.sv
// axi4_lite_mst: single-outstanding AXI4-Lite initiator that turns local
// commands into AW/W/B or AR/R transactions with a completion watchdog.
module axi4_lite_mst #(
    parameter int          U_DLY   = 1,
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic        axi4_lite_clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        aw_done;
    logic        w_done;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] wd_cnt;
    logic        busy;
    logic        wd_fire;
    logic        accept;
    logic        aw_hs;
    logic        w_hs;

    if (U_DLY < 0) begin : g_udly_chk
        $error("U_DLY must not be negative");
    end

    assign busy    = (state != IDLE) && (state != DONE);
    assign wd_fire = busy && (TIMEOUT != 16'd0)
                     && ((wd_cnt + 16'd1) == TIMEOUT);
    assign accept  = cmd_valid && cmd_ready;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = 4'hF;

    always_ff @(posedge axi4_lite_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = cmd_wr ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                if (wd_fire) begin
                    state_nxt = DONE;
                end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = WR_B;
                end
            end
            WR_B: begin
                if (wd_fire || bvalid) begin
                    state_nxt = DONE;
                end
            end
            RD_AR: begin
                if (wd_fire) begin
                    state_nxt = DONE;
                end else if (arready) begin
                    state_nxt = RD_R;
                end
            end
            RD_R: begin
                if (wd_fire || rvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state so async reset drops them at once
    always_comb begin
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: cmd_ready = 1'b1;
            WR_AW_W: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
            end
            WR_B:  bready    = 1'b1;
            RD_AR: arvalid   = 1'b1;
            RD_R:  rready    = 1'b1;
            DONE:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge axi4_lite_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            wd_cnt      <= 16'd0;
            rsp_rdata   <= 32'd0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= {cmd_addr[31:2], 2'b00};
                wdata_q <= cmd_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                wd_cnt  <= 16'd0;
            end else if (busy) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
            // The watchdog outranks a handshake landing in the same cycle
            if (wd_fire) begin
                rsp_rdata   <= 32'd0;
                rsp_resp    <= 2'b10;
                rsp_timeout <= 1'b1;
            end else if (bvalid && bready) begin
                rsp_rdata   <= 32'd0;
                rsp_resp    <= bresp;
                rsp_timeout <= 1'b0;
            end else if (rvalid && rready) begin
                rsp_rdata   <= rdata;
                rsp_resp    <= rresp;
                rsp_timeout <= 1'b0;
            end
        end
    end

endmodule
